// File: rtl/rv_serial_io.sv
// rv_serial_io: memory-mapped 8N1 debug UART (inverted-polarity pins) with status/control regs and irq.
// Build option SIO_FIFO_EN: FIFO_DEPTH-entry TX/RX FIFOs; when undefined each side is a one-byte holding register.

module sio_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       empty,
  output logic       full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
    // NOTE: every output gets a default first, so no path leaves a value held and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

module rv_serial_io #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic [4:0]  adr,
  input  logic        cs,
  input  logic        rdy,
  input  logic [3:0]  we,
  input  logic        re,
  input  logic [31:0] dw,
  output logic [31:0] dr,
  output logic        irq,
  output logic        txd,
  input  logic        rxd,
  input  logic        dsr,
  output logic        dtr,
  output logic        txen
);
`ifdef SIO_FIFO_EN
  localparam int DEPTH = FIFO_DEPTH;
`else
  localparam int DEPTH = FIFO_DEPTH / FIFO_DEPTH;
`endif

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  logic        wr_en, rd_en;
  logic [2:0]  reg_sel;
  logic [31:0] status;
  logic        tx_idle;

  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] div_q, div_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;
  logic [31:0] dr_q, dr_d;
  logic        irq_q, irq_d;
  logic        rx_meta_q, rx_sync_q, dsr_meta_q, dsr_sync_q;

  tx_state_e   tx_state_q, tx_state_d;
  logic [8:0]  tx_sr_q, tx_sr_d;
  logic [3:0]  tx_bits_q, tx_bits_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        txd_q, txd_d, txen_q, txen_d;
  logic        tx_push, tx_pop, tx_empty, tx_full, tx_start;
  logic [7:0]  tx_rdata;

  rx_state_e   rx_state_q, rx_state_d;
  logic [7:0]  rx_sr_q, rx_sr_d;
  logic [2:0]  rx_bits_q, rx_bits_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [16:0] rx_half;
  logic        rx_push, rx_pop, rx_empty, rx_full, rx_ovr_evt, rx_ferr_evt;
  logic [7:0]  rx_rdata;
  logic        unused_bits;

  assign wr_en       = cs && rdy && (we != 4'b0);
  assign rd_en       = cs && rdy && re;
  assign reg_sel     = adr[4:2];
  assign tx_push     = wr_en && (reg_sel == 3'd0);
  assign rx_pop      = rd_en && (reg_sel == 3'd0) && !rx_empty;
  assign tx_idle     = tx_empty && (tx_state_q == TX_IDLE);
  assign status      = {26'b0, dsr_sync_q, ferr_q, ovr_q, tx_idle, tx_full, !rx_empty};
  assign rx_half     = ({1'b0, div_q} + 17'd1) >> 1;
  assign unused_bits = ^{dw[31:16], adr[1:0]};

  sio_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(xreset), .push(tx_push), .wdata(dw[7:0]), .pop(tx_pop),
    .rdata(tx_rdata), .empty(tx_empty), .full(tx_full)
  );

  sio_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(xreset), .push(rx_push), .wdata(rx_sr_q), .pop(rx_pop),
    .rdata(rx_rdata), .empty(rx_empty), .full(rx_full)
  );

  // Register file, read mux and interrupt; sticky flags favour a new event over a same-cycle clear.
  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr_en) begin
      case (reg_sel)
        3'd1: begin
          ovr_d  = 1'b0;
          ferr_d = 1'b0;
        end
        3'd2:    ctrl_d = dw[2:0];
        3'd3:    div_d  = dw[15:0];
        default: ;
      endcase
    end
    if (rx_ovr_evt)  ovr_d  = 1'b1;
    if (rx_ferr_evt) ferr_d = 1'b1;

    dr_d = '0;
    if (rd_en) begin
      case (reg_sel)
        3'd0:    dr_d = rx_empty ? 32'h0 : {24'b0, rx_rdata};
        3'd1:    dr_d = status;
        3'd2:    dr_d = {29'b0, ctrl_q};
        3'd3:    dr_d = {16'b0, div_q};
        default: dr_d = '0;
      endcase
    end
    irq_d = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_idle);
  end

  // Transmitter: the bit counter reloads from div_q at each bit boundary, so DIV changes land there.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sr_d    = tx_sr_q;
    tx_bits_d  = tx_bits_q;
    tx_cnt_d   = tx_cnt_q;
    txd_d      = txd_q;
    txen_d     = txen_q;
    tx_start   = 1'b0;
    case (tx_state_q)
      TX_IDLE: tx_start = !tx_empty;
      TX_SHIFT: begin
        if (tx_cnt_q != 16'd0) begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end else if (tx_bits_q != 4'd0) begin
          txd_d     = tx_sr_q[0];
          tx_sr_d   = {1'b0, tx_sr_q[8:1]};
          tx_bits_d = tx_bits_q - 4'd1;
          tx_cnt_d  = div_q;
        end else if (!tx_empty) begin
          tx_start = 1'b1;
        end else begin
          tx_state_d = TX_IDLE;
          txd_d      = 1'b0;
          txen_d     = 1'b0;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    tx_pop = tx_start;
    if (tx_start) begin
      tx_state_d = TX_SHIFT;
      txd_d      = 1'b1;
      txen_d     = 1'b1;
      tx_sr_d    = {1'b0, ~tx_rdata};
      tx_bits_d  = 4'd9;
      tx_cnt_d   = div_q;
    end
  end

  // Receiver: rx_sync_q is the synchronized inverted line, so 1 means start bit / logic 0.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_sr_d     = rx_sr_q;
    rx_bits_d   = rx_bits_q;
    rx_cnt_d    = rx_cnt_q;
    rx_push     = 1'b0;
    rx_ovr_evt  = 1'b0;
    rx_ferr_evt = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = (rx_half == 17'd0) ? 16'd0 : 16'(rx_half - 17'd1);
        end
      end
      RX_START: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_sync_q) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = div_q;
          rx_bits_d  = 3'd0;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_sr_d  = {~rx_sync_q, rx_sr_q[7:1]};
          rx_cnt_d = div_q;
          if (rx_bits_q == 3'd7) rx_state_d = RX_STOP;
          else                   rx_bits_d  = rx_bits_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_ferr_evt = 1'b1;
          end else begin
            rx_push    = 1'b1;
            rx_ovr_evt = rx_full && !rx_pop;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xreset) begin
    if (!xreset) begin
      ctrl_q     <= '0;
      div_q      <= DEFAULT_DIV;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      dr_q       <= '0;
      irq_q      <= 1'b0;
      rx_meta_q  <= 1'b0;
      rx_sync_q  <= 1'b0;
      dsr_meta_q <= 1'b0;
      dsr_sync_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_sr_q    <= '0;
      tx_bits_q  <= '0;
      tx_cnt_q   <= '0;
      txd_q      <= 1'b0;
      txen_q     <= 1'b0;
      rx_state_q <= RX_IDLE;
      rx_sr_q    <= '0;
      rx_bits_q  <= '0;
      rx_cnt_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      div_q      <= div_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      dr_q       <= dr_d;
      irq_q      <= irq_d;
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      dsr_meta_q <= dsr;
      dsr_sync_q <= dsr_meta_q;
      tx_state_q <= tx_state_d;
      tx_sr_q    <= tx_sr_d;
      tx_bits_q  <= tx_bits_d;
      tx_cnt_q   <= tx_cnt_d;
      txd_q      <= txd_d;
      txen_q     <= txen_d;
      rx_state_q <= rx_state_d;
      rx_sr_q    <= rx_sr_d;
      rx_bits_q  <= rx_bits_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign dr   = dr_q;
  assign irq  = irq_q;
  assign txd  = txd_q;
  assign txen = txen_q;
  assign dtr  = ctrl_q[2];
endmodule

// File: tb/tb_rv_serial_io.sv
// Self-checking bench for rv_serial_io: register table, TX frame capture, RX scoreboard, irq and reset sequences.
`timescale 1ns/1ps

module tb_rv_serial_io;
  localparam logic [4:0] A_DATA = 5'h00, A_STAT = 5'h04, A_CTRL = 5'h08, A_DIV = 5'h0C;
`ifdef SIO_FIFO_EN
  localparam int          RX_SLOTS = 16;
  localparam logic [31:0] ST_TWO_QUEUED = 32'h0000_0000;
`else
  localparam int          RX_SLOTS = 1;
  localparam logic [31:0] ST_TWO_QUEUED = 32'h0000_0002;
`endif

  logic        clk, xreset;
  logic [4:0]  adr;
  logic        cs, rdy, re;
  logic [3:0]  we;
  logic [31:0] dw, dr;
  logic        irq, txd, rxd, dsr, dtr, txen;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];
  logic [7:0]  rx_exp_q[$];
  logic        samp[256];
  int          n_samp;

  typedef struct {
    logic        wr;
    logic [4:0]  adr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_dtr;
  } vec_t;
  vec_t vecs[14];

  rv_serial_io dut (
    .clk(clk), .xreset(xreset), .adr(adr), .cs(cs), .rdy(rdy), .we(we), .re(re),
    .dw(dw), .dr(dr), .irq(irq), .txd(txd), .rxd(rxd), .dsr(dsr), .dtr(dtr), .txen(txen)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    adr = a; dw = d; we = 4'hF; cs = 1'b1; rdy = 1'b1;
    @(negedge clk);
    we = 4'h0; cs = 1'b0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    adr = a; re = 1'b1; cs = 1'b1; rdy = 1'b1;
    @(negedge clk);
    re = 1'b0; cs = 1'b0;
    d = dr;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] got, want;
    sb_q.push_back(exp);
    bus_rd(a, got);
    want = sb_q.pop_front();
    check(name, got, want);
  endtask

  task automatic rd_data(input string name);
    logic [31:0] want;
    want = (rx_exp_q.size() != 0) ? {24'b0, rx_exp_q.pop_front()} : 32'h0;
    rd_chk(name, A_DATA, want);
  endtask

  // Inverted 8N1 frame at 4 clocks per bit (DIV=3).
  task automatic send_rx(input logic [7:0] b, input logic bad_stop, input logic keep);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      rxd = 1'b1;
      else if (k == 9) rxd = bad_stop;
      else             rxd = ~b[k-1];
      repeat (4) @(negedge clk);
    end
    rxd = 1'b0;
    if (keep) rx_exp_q.push_back(b);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b1;
    if (k == 9) return 1'b0;
    return ~b[k-1];
  endfunction

  task automatic wait_txen();
    int t = 0;
    while (!txen && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("txen_start", txen, 1);
  endtask

  task automatic capture_tx();
    n_samp = 0;
    while (txen && n_samp < 256) begin
      samp[n_samp] = txd;
      n_samp++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input int f, input logic [7:0] b);
    for (int k = 0; k < 10; k++)
      check($sformatf("tx_f%0d_bit%0d", f, k), samp[f*40 + 4*k + 2], frame_bit(b, k));
  endtask

  initial begin
    logic [31:0] st;
    int          t;
    xreset = 1'b1; adr = '0; cs = 1'b0; rdy = 1'b0; we = '0; re = 1'b0;
    dw = '0; rxd = 1'b0; dsr = 1'b0;
    #2 xreset = 1'b0;
    @(negedge clk);
    check("rst_txd", txd, 0);
    check("rst_txen", txen, 0);
    check("rst_irq", irq, 0);
    check("rst_dr", dr, 0);
    check("rst_dtr", dtr, 0);
    @(negedge clk);
    xreset = 1'b1;
    @(negedge clk);

    vecs[0]  = '{1'b0, A_STAT, 32'h0,         32'h4,    1'b0};
    vecs[1]  = '{1'b0, A_DIV,  32'h0,         32'd867,  1'b0};
    vecs[2]  = '{1'b0, A_CTRL, 32'h0,         32'h0,    1'b0};
    vecs[3]  = '{1'b1, A_CTRL, 32'h4,         32'h4,    1'b1};
    vecs[4]  = '{1'b1, A_CTRL, 32'hFFFF_FFF8, 32'h0,    1'b0};
    vecs[5]  = '{1'b1, 5'h0B,  32'h5,         32'h5,    1'b1};
    vecs[6]  = '{1'b1, A_DIV,  32'hABCD_1234, 32'h1234, 1'b1};
    vecs[7]  = '{1'b1, 5'h10,  32'hFFFF_FFFF, 32'h0,    1'b1};
    vecs[8]  = '{1'b1, 5'h15,  32'hFFFF_FFFF, 32'h0,    1'b1};
    vecs[9]  = '{1'b1, 5'h1A,  32'hFFFF_FFFF, 32'h0,    1'b1};
    vecs[10] = '{1'b1, 5'h1F,  32'hFFFF_FFFF, 32'h0,    1'b1};
    vecs[11] = '{1'b1, 5'h0E,  32'h3,         32'h3,    1'b1};
    vecs[12] = '{1'b1, A_CTRL, 32'h0,         32'h0,    1'b0};
    vecs[13] = '{1'b0, A_DIV,  32'h0,         32'h3,    1'b0};
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) bus_wr(vecs[i].adr, vecs[i].wdata);
      rd_chk($sformatf("reg_vec%0d", i), vecs[i].adr, vecs[i].exp);
      check($sformatf("dtr_vec%0d", i), dtr, vecs[i].exp_dtr);
    end

    // TX-idle interrupt, one clock behind CTRL.
    bus_wr(A_CTRL, 32'h2);
    check("irq_txidle_lag", irq, 0);
    @(negedge clk);
    check("irq_txidle", irq, 1);
    bus_wr(A_CTRL, 32'h0);
    @(negedge clk);
    check("irq_txidle_off", irq, 0);

    dsr = 1'b1;
    repeat (3) @(negedge clk);
    rd_chk("status_dsr", A_STAT, 32'h24);
    dsr = 1'b0;
    repeat (3) @(negedge clk);

    bus_wr(A_DATA, 32'h55);
    wait_txen();
    capture_tx();
    check("tx_len_one", n_samp, 40);
    check_frame(0, 8'h55);
    check("tx_line_idle", txd, 0);
    rd_chk("tx_idle_back", A_STAT, 32'h4);

    bus_wr(A_DATA, 32'hA5);
    bus_wr(A_DATA, 32'h0F);
    wait_txen();
    capture_tx();
    check("tx_len_two", n_samp, 80);
    check_frame(0, 8'hA5);
    check_frame(1, 8'h0F);

    bus_wr(A_DATA, 32'h11);
    bus_wr(A_DATA, 32'h22);
    rd_chk("tx_full_state", A_STAT, ST_TWO_QUEUED);
    t = 0;
    do begin
      bus_rd(A_STAT, st);
      t++;
    end while (!st[2] && t < 200);
    check("tx_idle_return", st[2], 1);

    send_rx(8'hA3, 1'b0, 1'b1);
    repeat (6) @(negedge clk);
    rd_chk("rx_avail", A_STAT, 32'h5);
    rd_data("rx_a3");
    rd_data("rx_empty_read");
    rd_chk("rx_drained", A_STAT, 32'h4);

    send_rx(8'h5A, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    rd_chk("frame_err_set", A_STAT, 32'h14);
    bus_wr(A_STAT, 32'h0);
    rd_chk("frame_err_clr", A_STAT, 32'h4);
    rd_data("frame_err_nobyte");

    for (int i = 1; i <= RX_SLOTS + 1; i++) send_rx(8'(i), 1'b0, i <= RX_SLOTS);
    repeat (6) @(negedge clk);
    rd_chk("overrun_set", A_STAT, 32'hD);
    for (int i = 0; i < RX_SLOTS; i++) rd_data($sformatf("rx_fill%0d", i));
    rd_data("rx_fill_empty");
    bus_wr(A_STAT, 32'h0);
    rd_chk("overrun_clr", A_STAT, 32'h4);

    // RX interrupt: reads gated by cs/rdy return 0 and do not pop.
    bus_wr(A_CTRL, 32'h1);
    send_rx(8'hC6, 1'b0, 1'b1);
    t = 0;
    while (!irq && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("irq_rx_rise", irq, 1);
    adr = A_DATA; cs = 1'b0; rdy = 1'b1; re = 1'b1;
    @(negedge clk);
    check("dr_cs_low", dr, 0);
    cs = 1'b1; rdy = 1'b0;
    @(negedge clk);
    check("dr_rdy_low", dr, 0);
    check("irq_no_pop", irq, 1);
    rdy = 1'b1;
    sb_q.push_back({24'b0, rx_exp_q.pop_front()});
    @(negedge clk);
    re = 1'b0; cs = 1'b0;
    check("rx_irq_byte", dr, sb_q.pop_front());
    check("irq_after_pop_lag", irq, 1);
    @(negedge clk);
    check("irq_after_pop", irq, 0);
    check("dr_back_to_zero", dr, 0);

    // Reset mid-frame with a byte pending and dr holding a value.
    send_rx(8'h3C, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    bus_wr(A_DATA, 32'h81);
    wait_txen();
    repeat (10) @(negedge clk);
    adr = A_STAT; cs = 1'b1; rdy = 1'b1; re = 1'b1;
    @(negedge clk);
    re = 1'b0; cs = 1'b0;
    check("st_before_rst", dr, 32'h1);
    check("irq_before_rst", irq, 1);
    check("txd_before_rst", txd, 1);
    xreset = 1'b0;
    #1;
    check("midrst_txd", txd, 0);
    check("midrst_txen", txen, 0);
    check("midrst_irq", irq, 0);
    check("midrst_dr", dr, 0);
    check("midrst_dtr", dtr, 0);
    @(negedge clk);
    xreset = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_status", A_STAT, 32'h4);
    rd_chk("post_rst_div", A_DIV, 32'd867);
    rd_chk("post_rst_ctrl", A_CTRL, 32'h0);
    rd_data("post_rst_rx_empty");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
